// File: rtl/bit_counter_pkg.sv
// Shared types and mode encodings for the parametrised bit counter.
package bit_counter_pkg;

    localparam logic [1:0] MODE_ENC_ONES  = 2'b00;
    localparam logic [1:0] MODE_ENC_ZEROS = 2'b01;
    localparam logic [1:0] MODE_ENC_LZ    = 2'b10;
    localparam logic [1:0] MODE_ENC_TZ    = 2'b11;

    typedef enum logic [1:0] {
        MODE_ONES  = MODE_ENC_ONES,
        MODE_ZEROS = MODE_ENC_ZEROS,
        MODE_LZ    = MODE_ENC_LZ,
        MODE_TZ    = MODE_ENC_TZ
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/bc_chunk_scan.sv
// Combinational scan of one chunk: popcount, MSB-first leading zeros, any-one flag.
module bc_chunk_scan #(
    parameter int BITS_PER_CYC = 1,
    localparam int PC_W = $clog2(BITS_PER_CYC + 1)
) (
    input  logic [BITS_PER_CYC-1:0] chunk_i,
    output logic [PC_W-1:0]         pop_o,
    output logic [PC_W-1:0]         lz_o,
    output logic                    has_one_o
);

    always_comb begin
        pop_o     = '0;
        lz_o      = PC_W'(BITS_PER_CYC);
        has_one_o = 1'b0;
        for (int unsigned j = 0; j < BITS_PER_CYC; j++) begin
            if (chunk_i[j]) begin
                pop_o = pop_o + PC_W'(1);
            end
        end
        // j walks from the MSB down; the first set bit fixes the leading-zero count
        for (int unsigned j = 0; j < BITS_PER_CYC; j++) begin
            if (!has_one_o && chunk_i[BITS_PER_CYC-1-j]) begin
                lz_o      = PC_W'(j);
                has_one_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_counter_param.sv
// Multi-cycle bit counter: ones, zeros, leading or trailing zeros of a DATA_W word,
// scanned BITS_PER_CYC bits per clock behind a Valid/Ready handshake.
module bit_counter_param
    import bit_counter_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int BITS_PER_CYC = 1,
    localparam int CNT_W       = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid,
    input  logic [1:0]        Mode,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Ready,
    output logic [CNT_W-1:0]  DataOut
);

    localparam int N     = DATA_W / BITS_PER_CYC;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W  = $clog2(BITS_PER_CYC + 1);

    state_t              state_q;
    mode_t               mode_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    dout_q;
    logic                ready_q;

    logic [DATA_W-1:0]   shreg_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [PC_W-1:0]     pop;
    logic [PC_W-1:0]     lz;
    logic [PC_W-1:0]     add;
    logic                has_one;
    logic                last;

    bc_chunk_scan #(
        .BITS_PER_CYC(BITS_PER_CYC)
    ) u_scan (
        .chunk_i   (shreg_q[DATA_W-1 -: BITS_PER_CYC]),
        .pop_o     (pop),
        .lz_o      (lz),
        .has_one_o (has_one)
    );

    // Trailing zeros are loaded bit-reversed so the scan only ever counts from the MSB
    always_comb begin
        shreg_d = DataIn;
        if (mode_t'(Mode) == MODE_TZ) begin
            for (int unsigned j = 0; j < DATA_W; j++) begin
                shreg_d[j] = DataIn[DATA_W-1-j];
            end
        end
    end

    always_comb begin
        add = lz;
        case (mode_q)
            MODE_ONES:  add = pop;
            MODE_ZEROS: add = PC_W'(BITS_PER_CYC) - pop;
            default:    add = lz;
        endcase
        cnt_d = cnt_q + CNT_W'(add);
        last  = (idx_q == IDX_W'(N - 1)) ||
                (((mode_q == MODE_LZ) || (mode_q == MODE_TZ)) && has_one);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_ONES;
            shreg_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Valid) begin
                        mode_q  <= mode_t'(Mode);
                        shreg_q <= shreg_d;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    cnt_q   <= cnt_d;
                    shreg_q <= shreg_q << BITS_PER_CYC;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last) begin
                        dout_q  <= cnt_d;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Ready   = ready_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_bit_counter_param.sv
// Directed bench for bit_counter_param (DATA_W=8, BITS_PER_CYC=2) with a latency/result model.
module tb_bit_counter_param;

    localparam int DW  = 8;
    localparam int BPC = 2;
    localparam int N   = DW / BPC;
    localparam int CW  = 4;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          Valid  = 1'b0;
    logic [1:0]    Mode   = 2'b00;
    logic [DW-1:0] DataIn = '0;
    logic          Ready;
    logic [CW-1:0] DataOut;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit_counter_param #(
        .DATA_W       (DW),
        .BITS_PER_CYC (BPC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Valid   (Valid),
        .Mode    (Mode),
        .DataIn  (DataIn),
        .Ready   (Ready),
        .DataOut (DataOut)
    );

    always #5 clk = ~clk;

    function automatic int m_ones(logic [DW-1:0] d);
        int c = 0;
        for (int i = 0; i < DW; i++) c += int'(d[i]);
        return c;
    endfunction

    function automatic int m_lz(logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--) if (d[i]) return DW - 1 - i;
        return DW;
    endfunction

    function automatic int m_tz(logic [DW-1:0] d);
        for (int i = 0; i < DW; i++) if (d[i]) return i;
        return DW;
    endfunction

    function automatic int m_result(logic [1:0] md, logic [DW-1:0] d);
        case (md)
            2'b00:   return m_ones(d);
            2'b01:   return DW - m_ones(d);
            2'b10:   return m_lz(d);
            default: return m_tz(d);
        endcase
    endfunction

    // Cycles from capture to Ready: full scan, or the chunk holding the first 1
    function automatic int m_lat(logic [1:0] md, logic [DW-1:0] d);
        int z;
        if (md[1] == 1'b0) return N;
        z = (md == 2'b10) ? m_lz(d) : m_tz(d);
        if (z == DW) return N;
        return z / BPC + 1;
    endfunction

    bit            m_busy = 1'b0;
    int            m_left = 0;
    int            m_res  = 0;
    logic          exp_ready = 1'b0;
    logic [CW-1:0] exp_dout  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_left    <= 0;
            exp_ready <= 1'b0;
            exp_dout  <= '0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy    <= 1'b0;
                exp_ready <= 1'b1;
                exp_dout  <= CW'(m_res);
            end else begin
                m_left <= m_left - 1;
            end
        end else if (Valid) begin
            m_busy    <= 1'b1;
            m_left    <= m_lat(Mode, DataIn);
            m_res     <= m_result(Mode, DataIn);
            exp_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (Ready !== exp_ready || DataOut !== exp_dout) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t Ready=%b DataOut=%0d expected Ready=%b DataOut=%0d",
                         $time, Ready, DataOut, exp_ready, exp_dout);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] md, input logic [DW-1:0] d);
        @(negedge clk);
        Valid  = 1'b1;
        Mode   = md;
        DataIn = d;
        @(negedge clk);
        Valid  = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Ready && n < 20);
        if (!Ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got Ready=0 expected Ready=1 within 20 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] md, input logic [DW-1:0] d,
                          input int exp_val, input int exp_lat);
        int n;
        start_op(md, d);
        check({name, "_rdy_low"}, int'(Ready), 0);
        wait_ready(name, n);
        check({name, "_lat"}, n, exp_lat);
        check({name, "_val"}, int'(DataOut), exp_val);
    endtask

    logic [DW-1:0] words [6] = '{8'h01, 8'h80, 8'h5A, 8'h3C, 8'h40, 8'h02};

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_ready", int'(Ready), 0);
        check("reset_dout", int'(DataOut), 0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        check("pin_model_lz10", m_result(2'b10, 8'h10), 3);
        check("pin_model_lat_tz08", m_lat(2'b11, 8'h08), 2);
        check("pin_model_lat_lz00", m_lat(2'b10, 8'h00), 4);

        run_op("ones_B4", 2'b00, 8'hB4, 4, 4);
        repeat (2) begin
            @(negedge clk);
            check("ones_hold_ready", int'(Ready), 1);
        end
        run_op("zeros_B4", 2'b01, 8'hB4, 4, 4);
        run_op("zeros_00", 2'b01, 8'h00, 8, 4);
        run_op("lz_10", 2'b10, 8'h10, 3, 2);
        run_op("lz_FF", 2'b10, 8'hFF, 0, 1);
        run_op("tz_00", 2'b11, 8'h00, 8, 4);
        run_op("tz_08", 2'b11, 8'h08, 3, 2);
        run_op("ones_FF", 2'b00, 8'hFF, 8, 4);

        for (int w = 0; w < 6; w++) begin
            for (int m = 0; m < 4; m++) begin
                run_op($sformatf("tbl_w%0d_m%0d", w, m), 2'(m), words[w],
                       m_result(2'(m), words[w]), m_lat(2'(m), words[w]));
            end
        end

        // Input churn during COUNT must not disturb the result
        start_op(2'b00, 8'hB4);
        check("churn_rdy_low", int'(Ready), 0);
        Valid = 1'b1; Mode = 2'b11; DataIn = 8'hFF;
        @(negedge clk);
        Valid = 1'b0; Mode = 2'b10; DataIn = 8'h00;
        @(negedge clk);
        Valid = 1'b1; Mode = 2'b01; DataIn = 8'h55;
        @(negedge clk);
        Valid = 1'b0; Mode = 2'b00; DataIn = 8'h00;
        @(negedge clk);
        check("churn_ready", int'(Ready), 1);
        check("churn_val", int'(DataOut), 4);

        start_op(2'b00, 8'h07);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", int'(Ready), 0);
        check("midrst_dout", int'(DataOut), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("postrst_idle_ready", int'(Ready), 0);
            check("postrst_idle_dout", int'(DataOut), 0);
        end
        run_op("after_rst", 2'b00, 8'h07, 3, 4);

        run_op("pre_b2b", 2'b10, 8'h10, 3, 2);
        @(negedge clk);
        Valid = 1'b1; Mode = 2'b00; DataIn = 8'h0F;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("b2b_wait%0d_ready", k), int'(Ready), 0);
            check($sformatf("b2b_wait%0d_dout", k), int'(DataOut), 3);
        end
        @(negedge clk);
        check("b2b_ready", int'(Ready), 1);
        check("b2b_val", int'(DataOut), 4);
        @(negedge clk);
        check("b2b_one_cycle", int'(Ready), 0);
        check("b2b_dout_kept", int'(DataOut), 4);
        Valid = 1'b0;
        begin
            int n;
            wait_ready("b2b_second", n);
            check("b2b_second_lat", n, 4);
            check("b2b_second_val", int'(DataOut), 4);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bit_counter_param.md
Name: bit_counter_param

Overview:
Parametrised successor of the single-byte bit counter used in the FPGA demo tops. It accepts a DATA_W-bit word on a Valid/Ready handshake and scans it BITS_PER_CYC bits per clock. It reports one of four counts, selected per operation: ones, zeros, leading zeros or trailing zeros. Leading- and trailing-zero modes terminate early. DataOut feeds the 7-segment decoder path; Ready gates the display.

Parameters:
DATA_W, 8, input word width; must be a multiple of BITS_PER_CYC.
BITS_PER_CYC, 1, bits consumed per COUNT cycle; legal values are 1, 2, 4 or 8.
CNT_W, $clog2(DATA_W+1), result width; derived, not overridden.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
Valid  in  1  start request; sampled only in IDLE or DONE.
Mode  in  2  operation select, sampled with Valid: 00 ones, 01 zeros, 10 leading zeros, 11 trailing zeros.
DataIn  in  DATA_W  word to scan; sampled with Valid.
Ready  out  1  result valid; high only in DONE.
DataOut  out  CNT_W  count result, zero-extended.

Behaviour:
- Reset (async, any state): state = IDLE, Ready = 0, DataOut = 0, internal shift register, count and mode cleared.
- Let N = DATA_W/BITS_PER_CYC.
- States:
  - IDLE: Ready = 0. Valid = 1 at an edge -> capture, go to COUNT.
  - COUNT: process one chunk per edge. Valid, Mode and DataIn are ignored.
  - DONE: Ready = 1, DataOut is held. Valid = 1 at an edge -> recapture, go to COUNT, Ready low in the next cycle.
- Capture:
  - Latch Mode.
  - Load the shift register with DataIn, or with bit-reversed DataIn for trailing-zero mode, so that TZ is computed as LZ.
  - Clear the internal count and chunk index.
  - DataOut keeps its previous value until the new result is written.
- Chunk = the top BITS_PER_CYC bits of the shift register. The register shifts left by BITS_PER_CYC each COUNT cycle.
- Ones mode: count += popcount(chunk).
- Zeros mode: count += BITS_PER_CYC - popcount(chunk).
- LZ/TZ modes: count += leading zeros of the chunk (MSB-first).
  - If the chunk contains a 1, the operation finishes at this edge (early termination).
  - Otherwise scanning continues.
- Completion edge (last chunk, or early termination): DataOut <= final count, state -> DONE. Ready is visible from the following cycle.
- Latency, from capture edge to Ready high:
  - Ones/zeros: always N cycles.
  - LZ/TZ: k cycles, where k is the 1-based index of the chunk holding the first 1; N if the word is all zeros.
- Width/boundary results:
  - All-zero word: LZ = TZ = zeros = DATA_W.
  - All-ones word: ones = DATA_W, LZ = 0 with latency 1.
  - Count never exceeds DATA_W, so there is no wrap.
- Valid held high continuously: operations repeat back-to-back. Ready is high for exactly one cycle per result.
- Reset asserted mid-COUNT: abort. No partial result reaches DataOut.

Decomposition:
- Package bit_counter_pkg:
  - mode_t enum: MODE_ONES, MODE_ZEROS, MODE_LZ, MODE_TZ.
  - state_t enum: IDLE, COUNT, DONE.
  - Mode encodings as constants.
- Sub-module bc_chunk_scan: purely combinational, parametrised on BITS_PER_CYC. Outputs:
  - popcount of the chunk.
  - leading-zero count of the chunk.
  - has_one flag.
- Top FSM, shift register and index counter live in bit_counter_param.

Test Plan:
1. DATA_W=8, BPC=2, Mode=00, DataIn=0xB4 -> DataOut=4; Ready rises 4 cycles after the capture edge and stays high.
2. Same configuration, Mode=01, DataIn=0xB4 -> DataOut=4. Then Mode=01, DataIn=0x00 -> DataOut=8.
3. Mode=10, DataIn=0x10 -> DataOut=3; Ready after 2 cycles (early termination). Mode=10, DataIn=0xFF -> DataOut=0 after 1 cycle.
4. Mode=11, DataIn=0x00 -> DataOut=8 after 4 cycles. Mode=11, DataIn=0x08 -> DataOut=3 after 2 cycles.
5. Toggle Valid, Mode and DataIn during COUNT -> no effect on the result. Then assert rst mid-COUNT -> Ready=0 and DataOut=0 immediately (async); after release the block is in IDLE.
6. Hold Valid=1 in DONE with a new word 0x0F, Mode=00 -> Ready falls the next cycle; DataOut keeps the old value until the new result 4 appears 4 cycles later.
